// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- four-slot time-division demultiplexer (receive side)
//
// Rebuilds four parallel channels from one serial slot stream. Slots arrive
// in order 0,1,2,3 with frame_sync marking slot 0. A small HUNT/LOCK
// machine tracks the slot position. Short gaps in frame_sync are bridged by
// flywheeling through up to MISS_MAX-1 missing syncs. A completed frame is
// published on Y in one update, together with a single-cycle frame_valid.
//
// Parameters:
//   W         width of each channel and of d_in
//   MISS_MAX  consecutive missing slot-0 syncs that drop LOCK back to HUNT (1..7)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   en           in   slot strobe; d_in/frame_sync are sampled only when en=1
//   d_in         in   serial slot data [W-1:0]
//   frame_sync   in   high together with the slot-0 sample
//   Y            out  channel n on Y[n*W +: W], holds the last complete frame
//   frame_valid  out  one-cycle pulse when Y is updated
//   locked       out  high while in LOCK
//   sync_err     out  one-cycle pulse when a sync arrives at a slot other than 0
//   slot         out  slot index expected on the next en edge
//
// Optional build (macro TDM_DEMUX_ERR_CNT_EN):
//   err_clr      in   synchronous clear of err_cnt (wins over an increment)
//   err_cnt      out  [7:0] saturating count of sync errors and lock losses
// -----------------------------------------------------------------------------
module tdm_demux4 #(
   parameter int W        = 1,
   parameter int MISS_MAX = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic [W-1:0]   d_in,
   input  logic           frame_sync,
`ifdef TDM_DEMUX_ERR_CNT_EN
   input  logic           err_clr,
   output logic [7:0]     err_cnt,
`endif
   output logic [4*W-1:0] Y,
   output logic           frame_valid,
   output logic           locked,
   output logic           sync_err,
   output logic [1:0]     slot
);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t         state_q, state_d;
   logic [1:0]     slot_q, slot_d;
   logic [2:0]     miss_q, miss_d;
   logic [W-1:0]   sh_q [3];
   logic [W-1:0]   sh_d [3];
   logic [4*W-1:0] y_q, y_d;
   logic           fv_q, fv_d;
   logic           serr_q, serr_d;
   logic [3:0]     miss_inc;
`ifdef TDM_DEMUX_ERR_CNT_EN
   logic           drop;
   logic [7:0]     err_cnt_q, err_cnt_d;
`endif

   assign miss_inc = {1'b0, miss_q} + 4'd1;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      miss_d  = miss_q;
      sh_d    = sh_q;
      y_d     = y_q;
      fv_d    = 1'b0;
      serr_d  = 1'b0;
`ifdef TDM_DEMUX_ERR_CNT_EN
      drop    = 1'b0;
`endif
      if (en) begin
         if (state_q == HUNT) begin
            if (frame_sync) begin
               sh_d[0] = d_in;
               slot_d  = 2'd1;
               miss_d  = 3'd0;
               state_d = LOCK;
            end
         end else if (frame_sync) begin
            // A sync anywhere restarts the frame; off slot 0 it is also an error.
            serr_d  = (slot_q != 2'd0);
            sh_d[0] = d_in;
            slot_d  = 2'd1;
            miss_d  = 3'd0;
         end else begin
            case (slot_q)
               2'd0: begin
                  // Flywheel: accept the sample as slot 0 without a sync,
                  // unless this miss exhausts the tolerance.
                  sh_d[0] = d_in;
                  if (miss_inc >= 4'(MISS_MAX)) begin
                     state_d = HUNT;
                     slot_d  = 2'd0;
                     miss_d  = 3'd0;
`ifdef TDM_DEMUX_ERR_CNT_EN
                     drop    = 1'b1;
`endif
                  end else begin
                     miss_d  = miss_inc[2:0];
                     slot_d  = 2'd1;
                  end
               end
               2'd1: begin
                  sh_d[1] = d_in;
                  slot_d  = 2'd2;
               end
               2'd2: begin
                  sh_d[2] = d_in;
                  slot_d  = 2'd3;
               end
               default: begin
                  // Slot 3 bypasses the shadow registers so Y updates on this edge.
                  y_d    = {d_in, sh_q[2], sh_q[1], sh_q[0]};
                  fv_d   = 1'b1;
                  slot_d = 2'd0;
               end
            endcase
         end
      end
   end

`ifdef TDM_DEMUX_ERR_CNT_EN
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr)
         err_cnt_d = 8'd0;
      else if ((serr_d || drop) && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_cnt_q <= 8'd0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         miss_q  <= 3'd0;
         sh_q[0] <= '0;
         sh_q[1] <= '0;
         sh_q[2] <= '0;
         y_q     <= '0;
         fv_q    <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         miss_q  <= miss_d;
         sh_q    <= sh_d;
         y_q     <= y_d;
         fv_q    <= fv_d;
         serr_q  <= serr_d;
      end
   end

   assign Y           = y_q;
   assign frame_valid = fv_q;
   assign sync_err    = serr_q;
   assign locked      = (state_q == LOCK);
   assign slot        = slot_q;

endmodule
